// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and port indices shared by mem_arbiter and arb_pick
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int PORT_CORE = 0;
  localparam int PORT_AUX = 1;
endpackage

// File: rtl/arb_pick.sv
// arb_pick: two-way one-hot picker; fixed port-0 priority, or round-robin tie-break
// when MEM_ARB_ROUNDROBIN_EN is defined
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] win
);
`ifdef MEM_ARB_ROUNDROBIN_EN
  logic tie_aux;
  // last_gnt holds the index of the port granted last; on a tie the other one wins
  assign tie_aux = &req && !last_gnt;
  assign win[PORT_CORE] = req[PORT_CORE] && !tie_aux;
  assign win[PORT_AUX] = req[PORT_AUX] && (!req[PORT_CORE] || tie_aux);
`else
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt;
  assign win[PORT_CORE] = req[PORT_CORE];
  assign win[PORT_AUX] = req[PORT_AUX] && !req[PORT_CORE];
`endif
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two requesters with LAT-cycle accesses
// MEM_ARB_ROUNDROBIN_EN: round-robin tie-break instead of fixed port-0 priority
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    we,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
  if (LAT < 1) begin : g_lat_check
    $error("mem_arbiter: LAT must be at least 1");
  end
  state_t        state;
  logic [CW-1:0] cnt;
  logic          owner, we_q, last_gnt;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic [1:0]    win, done_q;
  arb_pick u_pick (.req(req), .last_gnt(last_gnt), .win(win));
`ifdef MEM_ARB_ROUNDROBIN_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_gnt <= 1'b1;
    else if (|gnt) last_gnt <= gnt[PORT_AUX];
`else
  assign last_gnt = 1'b0;
`endif
  // grant is Mealy and must also vanish while reset is held low
  assign gnt = (state == IDLE && reset) ? win : 2'b00;
  assign done = done_q;
  assign rdata = |done_q ? rdata_q : '0;
  assign mem_en = state == BUSY;
  assign mem_we = mem_en && we_q && cnt == '0;
  assign mem_addr = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      owner <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q <= '0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          owner <= gnt[PORT_AUX];
          we_q <= gnt[PORT_AUX] ? we[PORT_AUX] : we[PORT_CORE];
          addr_q <= gnt[PORT_AUX] ? addr1 : addr0;
          wdata_q <= gnt[PORT_AUX] ? wdata1 : wdata0;
          cnt <= CW'(LAT - 1);
          state <= BUSY;
        end
        BUSY: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          if (!we_q) rdata_q <= mem_rdata;
          done_q <= owner ? 2'b10 : 2'b01;
          state <= RESP;
        end
        RESP: begin
          done_q <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven transactions with a done/rdata scoreboard, plus hand
// sequences for contention, reset mid-write and a LAT=1 instance
module tb_mem_arbiter;
  localparam int LAT = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] req = '0, we = '0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic [1:0] gnt, done;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic mem_en, mem_we;
  logic [31:0] mem [0:63] = '{default: 32'h0};
  logic [1:0] req1 = '0, gnt1, done1;
  logic [31:0] rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic mem_en1, mem_we1;
  int cyc = 0, n_chk = 0, n_pass = 0, last_p = 1;
  typedef struct {logic [1:0] port_oh; int cyc; logic rd; logic [31:0] data;} exp_t;
  typedef struct {int p; logic w; logic [31:0] a; logic [31:0] d; logic [31:0] exp_rd;} vec_t;
  exp_t sb[$];
  vec_t vecs[9];

  mem_arbiter #(.AW(32), .DW(32), .LAT(LAT)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt(gnt), .done(done), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  mem_arbiter #(.AW(32), .DW(32), .LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .we(2'b00), .addr0(32'h0), .addr1(32'h0),
    .wdata0(32'h0), .wdata1(32'h0), .gnt(gnt1), .done(done1), .rdata(rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_en && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata1 = (mem_en1 && mem_addr1 == 32'h0) ? 32'hA5A5A5A5 : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (|done) begin
      if (sb.size() == 0) chk("spurious_done", {62'b0, done}, 64'h0);
      else begin
        e = sb.pop_front();
        chk("done_port", {62'b0, done}, {62'b0, e.port_oh});
        chk("done_cycle", cyc, e.cyc);
        if (e.rd) chk("rdata", rdata, e.data);
      end
    end
  end

  task automatic run_txn(input int p, input logic w, input logic [31:0] a, d, exp_rd);
    exp_t e;
    @(negedge clk);
    req = 2'b01 << p;
    we = w ? 2'b01 << p : 2'b00;
    if (p == 0) begin addr0 = a; wdata0 = d; end
    else begin addr1 = a; wdata1 = d; end
    #1 chk("txn_gnt", gnt, 2'b01 << p);
    e.port_oh = 2'b01 << p; e.cyc = cyc + LAT + 1; e.rd = !w; e.data = exp_rd;
    sb.push_back(e);
    last_p = p;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk); #1;
      if (k == 1) begin req = '0; we = '0; end
      chk("txn_mem_en", mem_en, k <= LAT);
      chk("txn_mem_we", mem_we, w && k == LAT);
      if (k <= LAT) chk("txn_mem_addr", mem_addr, a);
      if (k <= LAT && w) chk("txn_mem_wdata", mem_wdata, d);
    end
    @(negedge clk); #1 chk("txn_idle_after", {mem_en, done}, 3'b0);
  endtask

  initial begin
    int t, prev, ep;
    exp_t e;
    vecs = '{'{1, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0},
             '{0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF},
             '{1, 1'b1, 32'h10, 32'h12345678, 32'h0},
             '{0, 1'b0, 32'h10, 32'h0, 32'h12345678},
             '{0, 1'b1, 32'h20, 32'h11111111, 32'h0},
             '{1, 1'b0, 32'h20, 32'h0, 32'h11111111},
             '{1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF},
             '{0, 1'b1, 32'hFC, 32'hCAFEF00D, 32'h0},
             '{0, 1'b0, 32'hFC, 32'h0, 32'hCAFEF00D}};
    req = 2'b11;
    #1 reset = 1'b0;
    #1;
    chk("rst_gnt", gnt, 0); chk("rst_done", done, 0); chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0); chk("rst_rdata", rdata, 0);
    repeat (2) @(negedge clk);
    req = '0; reset = 1'b1;
    for (int i = 0; i < 9; i++) run_txn(vecs[i].p, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd);
    // both ports requesting back to back
    addr0 = 32'h40; addr1 = 32'h10; we = '0;
    @(negedge clk); req = 2'b11; #1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (gnt == 2'b00 && t < 10) begin @(negedge clk); #1; t++; end
      chk("arb_wait", t < 10, 1);
`ifdef MEM_ARB_ROUNDROBIN_EN
      ep = 1 - last_p;
`else
      ep = 0;
`endif
      last_p = ep;
      chk("arb_gnt", gnt, 2'b01 << ep);
      if (i > 0) chk("arb_spacing", cyc - prev, LAT + 2);
      prev = cyc;
      e.port_oh = 2'b01 << ep; e.cyc = cyc + LAT + 1; e.rd = 1'b1;
      e.data = ep == 0 ? 32'hDEADBEEF : 32'h12345678;
      sb.push_back(e);
      @(negedge clk); #1;
      if (i == 3) req = '0;
    end
    repeat (LAT + 2) @(negedge clk);
    // reset asserted while the write strobe is up
    @(negedge clk);
    req = 2'b01; we = 2'b01; addr0 = 32'h20; wdata0 = 32'h55AA55AA;
    #1 chk("rw_gnt", gnt, 2'b01);
    @(negedge clk); #1 req = '0; we = '0;
    @(posedge clk); #1 chk("rw_pre_we", mem_we, 1);
    req = 2'b01; reset = 1'b0;
    #1;
    chk("rw_mem_we", mem_we, 0); chk("rw_mem_en", mem_en, 0);
    chk("rw_gnt_low", gnt, 0); chk("rw_done", done, 0);
    repeat (2) @(negedge clk);
    req = '0; last_p = 1;
    #1 reset = 1'b1;
    repeat (4) begin @(negedge clk); #1 chk("rw_idle", {mem_en, done}, 3'b0); end
    chk("rw_mem_kept", mem[8], 32'h11111111);
    run_txn(0, 1'b0, 32'h20, 32'h0, 32'h11111111);
    // LAT=1 instance: single BUSY cycle
    @(negedge clk); req1 = 2'b01;
    #1 chk("l1_gnt", gnt1, 2'b01);
    @(negedge clk); #1 req1 = '0;
    chk("l1_mem_en", mem_en1, 1); chk("l1_mem_we", mem_we1, 0);
    chk("l1_mem_wdata", mem_wdata1, 0); chk("l1_done_early", done1, 0);
    @(negedge clk); #1;
    chk("l1_done", done1, 2'b01); chk("l1_rdata", rdata1, 32'hA5A5A5A5);
    chk("l1_mem_en_off", mem_en1, 0);
    @(negedge clk); #1 chk("l1_done_pulse", done1, 0);
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog timeout");
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port data memory between two requesters: port 0 is the multicycle core's load/store path, port 1 is a loader/debug master.
- Accepts one transaction at a time and holds the memory for LAT wait cycles.
- Returns read data, or write completion, to the owning port with a one-cycle done pulse.
- Sits between the core's adr/writedata/memwrite interface and dmem; the core's FSM stalls until done.

Parameters:
- AW, 32, address width (byte address, passed through unchanged).
- DW, 32, data width.
- LAT, 2, memory access cycles per transaction; LAT must be at least 1, and LAT=0 is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  2  per-port request; bit i belongs to port i.
- we  in  2  per-port write enable, sampled at grant.
- addr0, addr1  in  AW  per-port address, sampled at grant.
- wdata0, wdata1  in  DW  per-port write data, sampled at grant.
- gnt  out  2  one-hot grant, combinational (Mealy), asserted in the acceptance cycle.
- done  out  2  one-hot completion pulse, registered, 1 cycle.
- rdata  out  DW  read data; valid only while a done bit is set.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid in the last BUSY cycle.

Behaviour:
- State machine, enum IDLE / BUSY / RESP.
- IDLE:
  - If req != 0, pick winner w, assert gnt[w] this cycle.
  - At the edge, latch addr/we/wdata of w and owner=w; load cnt=LAT-1; go to BUSY.
  - If req == 0, stay in IDLE with all outputs 0.
- BUSY:
  - mem_en=1; mem_addr/mem_wdata come from the latched registers.
  - mem_we = latched_we AND (cnt==0): exactly one write strobe per write.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: capture mem_rdata into rdata_q (reads only; writes leave rdata_q unchanged); go to RESP.
- RESP:
  - done[owner]=1 and rdata=rdata_q for exactly one cycle; go to IDLE.
  - gnt is 0 in RESP.
- Latency: grant in cycle 0, BUSY for cycles 1..LAT, done in cycle LAT+1.
- Minimum spacing between grants is LAT+2 cycles.
- Arbitration: fixed priority, port 0 wins on a tie (see the optional feature for round-robin).
- Requesters:
  - Hold req until they see gnt.
  - Must drop req or present a new request in the cycle after done.
  - Deasserting req after gnt has no effect; the transaction completes.
- gnt, done and mem_* are never active for two ports at once.
- Only one transaction is outstanding at any time.
- Reset (reset==0, asynchronous), mid-transaction or otherwise:
  - State goes to IDLE; cnt=0; owner=0; rdata_q=0.
  - gnt, done, mem_en and mem_we go to 0 immediately.
  - Any in-flight transaction is dropped and no done is issued for it.
  - A write strobe never leaks after reset assertion.
- With LAT=1, BUSY lasts a single cycle, and that cycle both strobes the write and samples mem_rdata.

Optional Feature:
- Macro: MEM_ARB_ROUNDROBIN_EN.
- Defined: on a tie, the winner is the port not granted last.
  - last_gnt register resets to 1, so port 0 wins the first tie.
  - last_gnt updates on every grant.
  - A single requester always wins regardless of last_gnt.
- Undefined: fixed priority, port 0 always wins a tie, and no last_gnt register is built.

Decomposition:
- Package mem_arb_pkg: state enum (IDLE, BUSY, RESP); port index constants PORT_CORE=0, PORT_AUX=1.
- Sub-module arb_pick: combinational 2-way picker with inputs req[1:0] and last_gnt, output one-hot win[1:0]; the macro selects its policy.
- The FSM, counter and latch registers live in mem_arbiter.

Test Plan:
- Single read, LAT=2, port0 addr=0x40, mem holds 0xDEADBEEF: gnt[0] in cycle 0; mem_en in cycles 1-2; done[0] with rdata=0xDEADBEEF in cycle 3.
- Single write, port1 addr=0x10, wdata=0x12345678: mem_we high in cycle 2 only; done[1] in cycle 3; a read-back from port0 returns 0x12345678.
- Both ports request continuously, macro undefined: every grant goes to port0 and port1 never completes. With MEM_ARB_ROUNDROBIN_EN defined, grants alternate 0,1,0,1 with 4-cycle spacing.
- req[0] dropped in the cycle after gnt: the transaction still completes with done[0] in cycle 3; no second grant occurs.
- reset pulled low in cycle 2 of a port0 write: mem_we and mem_en go to 0 asynchronously; no done is issued; after release, state is IDLE and memory at the address is unchanged.
- LAT=1, port0 read of 0x00 holding 0xA5A5A5A5: gnt in cycle 0, mem_en in cycle 1, done[0] with 0xA5A5A5A5 in cycle 2.
